// File: rtl/vga_sync_gen.sv
// VGA raster timing driven by a pixel-strobe level sampled in the system clock domain.
// Counts dclk rising edges into h/v counters and registers sync, blank and frame markers.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TICK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dclk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       tick_err
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] GAP_MAX  = 4'(TICK_MAX);

  logic       s0_q, s1_q;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic [3:0] gap_q, gap_d;
  logic       tick_err_q, tick_err_d;
  logic       tick, h_wrap, v_wrap;

  always_comb begin
    tick          = s0_q & ~s1_q;
    h_wrap        = (h_q == H_LAST);
    v_wrap        = (v_q == V_LAST);
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = tick & h_wrap & v_wrap;
    if (tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      // Decode from the next-state counts so outputs line up with x/y on the same edge.
      hsync_d    = !((h_d >= HS_START) && (h_d < HS_END));
      vsync_d    = !((v_d >= VS_START) && (v_d < VS_END));
      video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
    end
    if (tick)                 gap_d = 4'd0;
    else if (gap_q >= GAP_MAX) gap_d = gap_q;
    else                      gap_d = gap_q + 4'd1;
    tick_err_d = tick_err_q | (gap_d >= GAP_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q          <= 1'b0;
      s1_q          <= 1'b0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      gap_q         <= 4'd0;
      tick_err_q    <= 1'b0;
    end else begin
      s0_q          <= dclk;
      s1_q          <= s0_q;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      gap_q         <= gap_d;
      tick_err_q    <= tick_err_d;
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign tick_err    = tick_err_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance plus a tiny-raster instance sharing stimulus,
// both compared every cycle against a tick-count model, plus table vectors and corner sequences.
module tb_vga_sync_gen;
  localparam int TICK_MAX = 8;
  localparam int BIG_FRAME = 800 * 525;
  localparam int SML_FRAME = 16 * 9;

  logic clk = 1'b0, rst_n = 1'b0, dclk = 1'b0;
  logic [9:0] bx, by, sx, sy;
  logic bhs, bvs, bvo, bfs, ber, shs, svs, svo, sfs, ser;

  always #5 clk = ~clk;

  vga_sync_gen u_big (.clk(clk), .rst_n(rst_n), .dclk(dclk), .x(bx), .y(by), .hsync(bhs),
    .vsync(bvs), .video_on(bvo), .frame_start(bfs), .tick_err(ber));

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(2), .TICK_MAX(TICK_MAX)) u_sml (.clk(clk), .rst_n(rst_n), .dclk(dclk),
    .x(sx), .y(sy), .hsync(shs), .vsync(svs), .video_on(svo), .frame_start(sfs), .tick_err(ser));

  // Reference: count accepted ticks; raster position is the tick count modulo line/frame length.
  int   m_ticks = 0, m_gap = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_fsb = 1'b0, m_fss = 1'b0, m_err = 1'b0;
  logic m_tick;
  assign m_tick = m_s1 & ~m_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ticks <= 0; m_gap <= 0; m_s1 <= 1'b0; m_s2 <= 1'b0;
      m_fsb <= 1'b0; m_fss <= 1'b0; m_err <= 1'b0;
    end else begin
      m_ticks <= m_ticks + (m_tick ? 1 : 0);
      m_fsb   <= m_tick && ((m_ticks + 1) % BIG_FRAME == 0);
      m_fss   <= m_tick && ((m_ticks + 1) % SML_FRAME == 0);
      if (m_tick) m_gap <= 0;
      else if (m_gap < TICK_MAX) m_gap <= m_gap + 1;
      m_err   <= m_err || (!m_tick && (m_gap + 1 >= TICK_MAX));
      m_s1    <= dclk;
      m_s2    <= m_s1;
    end
  end

  function automatic logic [24:0] exp_vec(int t, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb, logic fs, logic err);
    int ht, vt, xx, yy;
    logic hsy, vsy, von;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    xx  = t % ht;
    yy  = (t / ht) % vt;
    hsy = !((xx >= ha + hf) && (xx < ha + hf + hs));
    vsy = !((yy >= va + vf) && (yy < va + vf + vs));
    von = (t > 0) && (xx < ha) && (yy < va);
    return {xx[9:0], yy[9:0], hsy, vsy, von, fs, err};
  endfunction

  typedef struct { int t; int x; int y; logic hs; logic vs; logic vo; } vec_t;
  vec_t tbl[10];

  int checks = 0, failures = 0;
  int mode = 0, phase = 0, prev_ticks = 0;
  int hs_low = 0, fs_cyc = 0, fs_orig = 0, von_t = 0, vs_t = 0, vs_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    chk("mon_big", 32'({bx, by, bhs, bvs, bvo, bfs, ber}),
        32'(exp_vec(m_ticks, 640, 16, 96, 48, 480, 10, 2, 33, m_fsb, m_err)));
    chk("mon_sml", 32'({sx, sy, shs, svs, svo, sfs, ser}),
        32'(exp_vec(m_ticks, 8, 2, 3, 3, 4, 1, 2, 2, m_fss, m_err)));
    if (!bhs) hs_low++;
    if (sfs) begin
      fs_cyc++;
      if (sx == 10'd0 && sy == 10'd0) fs_orig++;
    end
    if (m_ticks != prev_ticks && m_ticks >= 1 && m_ticks <= SML_FRAME) begin
      if (svo) von_t++;
      if (!svs) begin
        vs_t++;
        if (!(sy == 10'd5 || sy == 10'd6)) vs_bad++;
      end
    end
    prev_ticks = m_ticks;
  endtask

  task automatic drive();
    case (mode)
      0: dclk = 1'b0;
      1: dclk = 1'b1;
      default: begin
        dclk  = (phase < 2);
        phase = (phase + 1) % 4;
      end
    endcase
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      drive();
    end
  endtask

  task automatic wait_ticks(int target);
    int budget;
    budget = (target - m_ticks) * 8 + 20;
    while (m_ticks < target && budget > 0) begin
      cyc(1);
      budget--;
    end
    if (m_ticks < target) chk("wait_ticks_timeout", 32'(m_ticks), 32'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mode  = 0;
    dclk  = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    phase = 0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_x"}, 32'(bx), 0);
    chk({tag, "_y"}, 32'(by), 0);
    chk({tag, "_hs"}, 32'(bhs), 1);
    chk({tag, "_vs"}, 32'(bvs), 1);
    chk({tag, "_vo"}, 32'(bvo), 0);
    chk({tag, "_fs"}, 32'(bfs), 0);
    chk({tag, "_err"}, 32'(ber), 0);
    chk({tag, "_sxy"}, 32'({sx, sy}), 0);
  endtask

  initial begin
    int base_hs, base_fs, base_fo, base_von, base_vs, base_bad, n;
    tbl[0] = '{1,   1,   0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{639, 639, 0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{640, 640, 0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{655, 655, 0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{656, 656, 0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{751, 751, 0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{752, 752, 0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{799, 799, 0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{800, 0,   1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{801, 1,   1, 1'b1, 1'b1, 1'b1};

    // Reset state and the quiet interval before the first tick.
    cyc(3);
    chk_reset_vals("rst_init");
    do_reset();
    cyc(1);
    chk("pre_tick_vo", 32'(bvo), 0);

    // Nominal period-4 strobe through the first line wrap.
    mode = 2;
    base_hs = hs_low;
    for (int i = 0; i < 10; i++) begin
      wait_ticks(tbl[i].t);
      chk($sformatf("tbl%0d_x", i), 32'(bx), 32'(tbl[i].x));
      chk($sformatf("tbl%0d_y", i), 32'(by), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_sync", i), 32'({bhs, bvs}), 32'({tbl[i].hs, tbl[i].vs}));
      chk($sformatf("tbl%0d_vo", i), 32'(bvo), 32'(tbl[i].vo));
    end
    chk("hsync_low_cycles", 32'(hs_low - base_hs), 96 * 4);

    // Random-length strobe patterns, checked every cycle by the model.
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 2);
      cyc($urandom_range(1, 12));
    end

    // Full frame on the small raster.
    do_reset();
    mode = 2;
    base_fs = fs_cyc; base_fo = fs_orig; base_von = von_t; base_vs = vs_t; base_bad = vs_bad;
    wait_ticks(SML_FRAME + 6);
    chk("frame_pulses", 32'(fs_cyc - base_fs), 1);
    chk("frame_at_origin", 32'(fs_orig - base_fo), 1);
    chk("video_on_ticks", 32'(von_t - base_von), 32);
    chk("vsync_low_ticks", 32'(vs_t - base_vs), 32);
    chk("vsync_bad_rows", 32'(vs_bad - base_bad), 0);

    // Stall after x=100, then resume.
    do_reset();
    mode = 2;
    wait_ticks(100);
    mode = 0;
    dclk = 1'b0;
    n = 0;
    while (!ber && n < 30) begin
      cyc(1);
      n++;
    end
    chk("stall_err_delay", 32'(n), 8);
    chk("stall_x_hold", 32'(bx), 100);
    mode = 2;
    cyc(24);
    chk("resume_x_adv", 32'(bx > 10'd100), 1);
    chk("resume_err_sticky", 32'(ber), 1);

    // dclk held high: one tick only.
    do_reset();
    mode = 1;
    cyc(50);
    chk("const_hi_x", 32'(bx), 1);
    chk("const_hi_err", 32'(ber), 1);

    // Asynchronous reset at the last raster position of the small instance.
    do_reset();
    mode = 2;
    wait_ticks(SML_FRAME - 1);
    chk("near_wrap_pos", 32'({sx, sy}), 32'({10'd15, 10'd8}));
    base_fs = fs_cyc;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_async");
    mode = 0;
    dclk = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    mode = 1;
    dclk = 1'b1;
    cyc(1);
    chk("lat_edge1_x", 32'(sx), 0);
    cyc(1);
    chk("lat_edge2_xy", 32'({sx, sy}), 32'({10'd1, 10'd0}));
    cyc(20);
    chk("no_fs_after_rst", 32'(fs_cyc - base_fs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
